fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the instruction fetch stage.
- Owns the program counter and issues one outstanding request at a time to instruction memory over a req/gnt/rvalid handshake.
- Presents fetched instructions to decode over a valid/ready interface and applies branch/jump redirects with squash of in-flight fetches.
- Sits between the instruction memory and the decode stage inside riscv_top.

Parameters:
XLEN, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on if_instr when no instruction is held (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
fetch_en  input  1  enables issuing new fetch requests
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address, word aligned
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction word
redirect_valid  input  1  branch/jump taken; load new PC
redirect_pc  input  XLEN  redirect target
if_valid  output  1  instruction held for decode
if_pc  output  XLEN  PC of held instruction
if_instr  output  32  held instruction
id_ready  input  1  decode accepts held instruction

Behaviour:
- Reset (reset=0, async) forces:
  - state=IDLE, pc=RESET_PC, squash=0
  - imem_req=0, imem_addr=RESET_PC
  - if_valid=0, if_pc=0, if_instr=NOP_INSTR
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- imem_addr always equals pc, with bits [1:0] forced to 0. redirect_pc[1:0] are ignored.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - imem_req=0.
  - fetch_en=1 -> REQ next cycle.
- REQ:
  - imem_req=1.
  - imem_gnt=1 -> latch inflight_pc=pc, pc<=pc+4 (modulo 2^XLEN, wraps 0xFFFF_FFFC -> 0), go to WAIT.
  - imem_gnt=0 -> stay in REQ, holding imem_req and imem_addr stable.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 and squash=0 -> if_instr<=imem_rdata, if_pc<=inflight_pc, if_valid<=1, go to HOLD.
  - imem_rvalid=1 and squash=1 -> drop data, clear squash, go to REQ if fetch_en else IDLE.
- HOLD:
  - if_valid=1.
  - id_ready=1 -> if_valid<=0, if_instr<=NOP_INSTR, go to REQ if fetch_en else IDLE.
  - id_ready=0 -> outputs held stable.
- Redirect (redirect_valid=1) has highest priority in every state:
  - pc<=redirect_pc.
  - In IDLE/HOLD: if_valid<=0, if_instr<=NOP_INSTR, go to REQ if fetch_en else IDLE.
  - In REQ with imem_gnt=0: request retargets next cycle; stay in REQ.
  - In REQ with imem_gnt=1: the granted old-PC request is outstanding; squash<=1, go to WAIT, pc<=redirect_pc (not +4).
  - In WAIT with imem_rvalid=0: squash<=1, stay in WAIT.
  - In WAIT with imem_rvalid=1: data dropped, squash<=0, go to REQ/IDLE per fetch_en.
- fetch_en deassert:
  - Never aborts an outstanding request; WAIT always drains.
  - A held instruction remains until accepted.
  - Deassert while in REQ with imem_gnt=0 -> IDLE next cycle, imem_req=0.
- Throughput: at most one instruction per 3 cycles with single-cycle memory; exactly one request outstanding.
- Reset mid-WAIT: state and squash clear immediately. A late imem_rvalid arriving in IDLE/REQ is ignored.

Test Plan:
- Release reset, fetch_en=1, memory grants same cycle and returns rdata=pc^32'hA5A5_0000 one cycle later, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8. if_pc matches, with if_valid pulses every 3 cycles.
- Hold id_ready=0 for 5 cycles while in HOLD -> if_valid, if_pc=0x4, and if_instr stay stable; imem_req stays 0. Set id_ready=1 -> next request at 0x8.
- Assert redirect_valid with redirect_pc=0x103 during WAIT (fetch of 0x8) -> returned word is dropped with no if_valid. Next imem_addr=0x100, then if_pc=0x100.
- Assert redirect_pc=0x200 in REQ with imem_gnt=1 at the same cycle -> the 0xC response is squashed. Next request is at 0x200, not 0x204.
- Set RESET_PC=0xFFFF_FFFC, let one fetch complete -> next imem_addr=0x0.
- Pull reset low while in WAIT -> immediately imem_req=0, if_valid=0, if_instr=0x13. A stale rvalid the next cycle produces no if_valid.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one outstanding
// imem request at a time, holds the returned word for decode and applies
// branch/jump redirects, squashing any fetch already in flight.
//
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   fetch_en            permits new fetch requests
//   imem_req/addr       request to instruction memory (addr word aligned)
//   imem_gnt            memory accepted the request this cycle
//   imem_rvalid/rdata   memory response
//   redirect_valid/pc   taken branch/jump target
//   if_valid/pc/instr   instruction held for decode
//   id_ready            decode accepts the held instruction
module fetch_ctrl #(
    parameter int unsigned        XLEN      = 32,
    parameter logic [XLEN-1:0]    RESET_PC  = '0,
    parameter logic [31:0]        NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    input  logic            id_ready
);

    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   inflight_pc_q, inflight_pc_d;
    logic              squash_q, squash_d;
    logic              if_valid_q, if_valid_d;
    logic [XLEN-1:0]   if_pc_q, if_pc_d;
    logic [ILEN-1:0]   if_instr_q, if_instr_d;

    logic [XLEN-1:0]   redir_pc_c;
    state_e            resume_c;
    logic              unused_redir_lsb;

    // Low target bits are discarded: fetches are always word aligned.
    assign redir_pc_c       = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc[1:0];

    // Where to go once nothing is outstanding or held.
    assign resume_c = fetch_en ? S_REQ : S_IDLE;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            squash_q      <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
        end
    end

    // Next-state logic; redirect takes priority in every state.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        squash_d      = squash_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;

        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    pc_d       = redir_pc_c;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = resume_c;
                end else if (fetch_en) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (imem_gnt) begin
                    // The granted request is outstanding either way; a
                    // concurrent redirect marks its response for dropping.
                    inflight_pc_d = pc_q;
                    state_d       = S_WAIT;
                    if (redirect_valid) begin
                        pc_d     = redir_pc_c;
                        squash_d = 1'b1;
                    end else begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end else if (redirect_valid) begin
                    pc_d = redir_pc_c;
                end else if (!fetch_en) begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redir_pc_c;
                end
                if (imem_rvalid) begin
                    if (squash_q || redirect_valid) begin
                        squash_d = 1'b0;
                        state_d  = resume_c;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = inflight_pc_q;
                        if_valid_d = 1'b1;
                        state_d    = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    squash_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redir_pc_c;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = resume_c;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                    state_d    = resume_c;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = {pc_q[XLEN-1:2], 2'b00};
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

endmodule
